stream_burst_arbiter: RTL and testbench

- Shares one downstream narrow-stream consumer, normally a stream upsizer with SCALE = BEATS, among NUM_SRC requesting byte streams.
- Grants one source at a time for exactly BEATS accepted beats, so every packed output word holds data from a single source.
- Round-robin fairness between sources.
- Emits a source tag and a last-beat flag so the sink can route each packed word.

---
 rtl/stream_burst_arbiter.sv | 115 +++++++++++
 tb/tb_stream_burst_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_burst_arbiter.sv
// Round-robin burst arbiter: grants one byte stream at a time for exactly BEATS
// accepted beats so each packed word downstream comes from a single source.
module stream_burst_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DW      = 8,
    parameter int BEATS   = 4,
    localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*DW-1:0] s_data_i,
    input  logic [NUM_SRC-1:0]    s_valid_i,
    output logic [NUM_SRC-1:0]    s_ready_o,
    output logic [DW-1:0]         m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [SW-1:0]         m_src_o,
    output logic                  m_last_o
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [SW-1:0] LAST_INIT = SW'(NUM_SRC - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   grant_r;
    logic [SW-1:0]   last_srv_r;
    logic [CW-1:0]   cnt_r;
    logic [SW-1:0]   pick_s;
    logic            busy_s;
    logic            valid_s;
    logic            accept_s;

    // First requester strictly after 'last' in rotating order; the loop runs
    // from the farthest offset down so the nearest requester wins.
    function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                              input logic [SW-1:0]      last);
        logic [SW-1:0] pick;
        int            idx;
        pick = last;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_SRC;
            if (req[idx]) begin
                pick = SW'(idx);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Combinational pass-through of the granted source while a burst is open.
    always_comb begin
        pick_s   = rr_pick(s_valid_i, last_srv_r);
        busy_s   = (state_r == BUSY);
        valid_s  = busy_s & s_valid_i[grant_r];
        accept_s = valid_s & m_ready_i;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (busy_s && (grant_r == SW'(k))) begin
                s_ready_o[k] = m_ready_i;
            end else begin
                s_ready_o[k] = 1'b0;
            end
        end
        m_data_o  = s_data_i[grant_r*DW +: DW];
        m_valid_o = valid_s;
        m_src_o   = grant_r;
        m_last_o  = valid_s & (cnt_r == CNT_LAST);
    end

    // Arbitration FSM: IDLE samples requests once, BUSY counts accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            last_srv_r <= LAST_INIT;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|s_valid_i) begin
                        grant_r <= pick_s;
                        cnt_r   <= '0;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (accept_s) begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r      <= '0;
                            last_srv_r <= grant_r;
                            state_r    <= IDLE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Self-checking bench for stream_burst_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_stream_burst_arbiter;

    localparam int NA    = 2;
    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic [1:0]  s_valid = '0;
    logic [1:0]  s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_src;
    logic        m_last;

    logic [23:0] s_data3 = '0;
    logic [2:0]  s_valid3 = '0;
    logic [2:0]  s_ready3;
    logic [7:0]  m_data3;
    logic        m_valid3;
    logic        m_ready3 = 1'b0;
    logic [1:0]  m_src3;
    logic        m_last3;

    stream_burst_arbiter #(.NUM_SRC(2), .DW(8), .BEATS(BEATS)) dut (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready), .m_data_o(m_data), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_src_o(m_src), .m_last_o(m_last));

    stream_burst_arbiter #(.NUM_SRC(3), .DW(8), .BEATS(BEATS)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data3), .s_valid_i(s_valid3),
        .s_ready_o(s_ready3), .m_data_o(m_data3), .m_valid_o(m_valid3),
        .m_ready_i(m_ready3), .m_src_o(m_src3), .m_last_o(m_last3));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the stream, beats still owed, last served.
    int owner  = -1;
    int left   = 0;
    int served = NA - 1;

    int   last_q[$];
    int   last3_q[$];
    int   acc_cnt = 0;
    int   b_bad = 0;
    logic smp_valid;
    logic smp_src;

    typedef struct {
        logic [1:0] sv;
        logic       rdy;
        logic [7:0] d0;
        logic       ev;
        logic       el;
        logic [1:0] er;
    } vec_t;
    vec_t tbl[10];

    function automatic int rr_next(logic [1:0] req, int after);
        for (int k = 1; k <= NA; k++) begin
            if (req[(after + k) % NA]) return (after + k) % NA;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; left = 0; served = NA - 1;
    endtask

    task automatic model_step();
        if (owner < 0) begin
            if (s_valid != 2'b00) begin
                owner = rr_next(s_valid, served);
                left  = BEATS;
            end
        end else if (s_valid[owner] && m_ready) begin
            left--;
            if (left == 0) begin
                served = owner;
                owner  = -1;
            end
        end
    endtask

    task automatic check(string tag, logic ok, string got, string want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, want %s", tag, got, want);
        end
    endtask

    task automatic check_a(string tag);
        logic       ev, el;
        logic [1:0] er;
        logic [7:0] ed;
        ev = 1'b0; el = 1'b0; er = 2'b00; ed = 8'h00;
        if (owner >= 0) begin
            ev = s_valid[owner];
            el = ev && (left == 1);
            er = m_ready ? (2'b01 << owner) : 2'b00;
            ed = s_data[owner*8 +: 8];
        end
        check(tag, (m_valid === ev) && (m_last === el) && (s_ready === er) &&
                   (!ev || m_data === ed) && (owner < 0 || m_src === 1'(owner)),
              $sformatf("v=%b l=%b r=%b d=%h src=%0d", m_valid, m_last, s_ready, m_data, m_src),
              $sformatf("v=%b l=%b r=%b d=%h src=%0d", ev, el, er, ed, owner));
    endtask

    // One clock: sample and check at negedge, advance the model at posedge.
    task automatic cycle_a(string tag);
        @(negedge clk);
        check_a(tag);
        smp_valid = m_valid;
        smp_src   = m_src;
        if (m_valid && m_ready) acc_cnt++;
        if (m_valid && m_ready && m_last) last_q.push_back(int'(m_src));
        if (m_valid3 && m_ready3 && m_last3) last3_q.push_back(int'(m_src3));
        if (s_ready3[1] || (m_valid3 && m_data3 !== (8'h30 + {6'b0, m_src3}))) b_bad++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = '0; m_ready = 1'b0; s_valid3 = '0; m_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              s_ready === 2'b00 && !m_valid && !m_last && m_src === 1'b0 &&
              s_ready3 === 3'b000 && !m_valid3 && !m_last3 && m_src3 === 2'b00,
              $sformatf("r=%b v=%b l=%b src=%0d r3=%b v3=%b src3=%0d",
                        s_ready, m_valid, m_last, m_src, s_ready3, m_valid3, m_src3),
              "all zero");
        rst_n = 1'b1;
        model_reset();
        last_q.delete(); last3_q.delete(); acc_cnt = 0;
    endtask

    initial begin
        // Single source 0 with ready held high: two grants with one bubble.
        tbl[0] = '{2'b01, 1'b1, 8'h10, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{2'b01, 1'b1, 8'h10, 1'b1, 1'b0, 2'b01};
        tbl[2] = '{2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 2'b01};
        tbl[3] = '{2'b01, 1'b1, 8'h12, 1'b1, 1'b0, 2'b01};
        tbl[4] = '{2'b01, 1'b1, 8'h13, 1'b1, 1'b1, 2'b01};
        tbl[5] = '{2'b01, 1'b1, 8'h14, 1'b0, 1'b0, 2'b00};
        tbl[6] = '{2'b01, 1'b1, 8'h14, 1'b1, 1'b0, 2'b01};
        tbl[7] = '{2'b01, 1'b1, 8'h15, 1'b1, 1'b0, 2'b01};
        tbl[8] = '{2'b01, 1'b1, 8'h16, 1'b1, 1'b0, 2'b01};
        tbl[9] = '{2'b01, 1'b1, 8'h17, 1'b1, 1'b1, 2'b01};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_valid = tbl[i].sv; m_ready = tbl[i].rdy; s_data = {8'hEE, tbl[i].d0};
            @(negedge clk);
            check($sformatf("table[%0d]", i),
                  m_valid === tbl[i].ev && m_last === tbl[i].el && s_ready === tbl[i].er &&
                  m_src === 1'b0 && (!tbl[i].ev || m_data === tbl[i].d0),
                  $sformatf("v=%b l=%b r=%b src=%0d d=%h", m_valid, m_last, s_ready, m_src, m_data),
                  $sformatf("v=%b l=%b r=%b src=0 d=%h", tbl[i].ev, tbl[i].el, tbl[i].er, tbl[i].d0));
            @(posedge clk);
            model_step();
            #1;
        end

        // Round robin with both sources requesting.
        do_reset();
        s_data = 16'hB1A0; s_valid = 2'b11; m_ready = 1'b1;
        for (int i = 0; i < 22; i++) cycle_a("rr_cycle");
        check("rr_count", last_q.size() >= 4, $sformatf("%0d grants", last_q.size()), ">=4 grants");
        for (int i = 0; i < 4 && i < last_q.size(); i++)
            check($sformatf("rr_order[%0d]", i), last_q[i] == (i % 2),
                  $sformatf("src %0d", last_q[i]), $sformatf("src %0d", i % 2));

        // Backpressure: ready low for 3 cycles at beat 2.
        do_reset();
        s_data = 16'h5A3C; s_valid = 2'b01; m_ready = 1'b1;
        repeat (3) cycle_a("bp_run");
        m_ready = 1'b0;
        repeat (3) cycle_a("bp_stall");
        m_ready = 1'b1;
        repeat (2) cycle_a("bp_finish");
        s_valid = 2'b00;
        repeat (3) cycle_a("bp_drain");
        check("bp_beats", acc_cnt == 4, $sformatf("%0d beats", acc_cnt), "4 beats");

        // Source stall: source 1 drops valid after its first beat.
        do_reset();
        s_data = 16'h7766; s_valid = 2'b10; m_ready = 1'b1;
        repeat (2) cycle_a("stall_start");
        s_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            cycle_a("stall_hold");
            check("stall_grant_held", smp_src === 1'b1 && smp_valid === 1'b0,
                  $sformatf("src=%0d v=%b", smp_src, smp_valid), "src=1 v=0");
        end
        s_valid = 2'b11;
        repeat (5) cycle_a("stall_resume");
        check("stall_next_grant", smp_src === 1'b0 && smp_valid === 1'b1,
              $sformatf("src=%0d v=%b", smp_src, smp_valid), "src=0 v=1");
        check("stall_lasts", last_q.size() == 1 && last_q[0] == 1,
              $sformatf("%0d lasts", last_q.size()), "one last from src 1");

        // Asynchronous reset in the middle of source 1's burst.
        do_reset();
        s_data = 16'h4433; s_valid = 2'b11; m_ready = 1'b1;
        repeat (8) cycle_a("rst_run");
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              s_ready === 2'b00 && !m_valid && !m_last && m_src === 1'b0,
              $sformatf("r=%b v=%b l=%b src=%0d", s_ready, m_valid, m_last, m_src), "all zero");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cycle_a("rst_regrant");
        check("rst_first_grant", smp_src === 1'b0 && smp_valid === 1'b1,
              $sformatf("src=%0d v=%b", smp_src, smp_valid), "src=0 v=1");

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s_valid = 2'($urandom_range(0, 3));
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            cycle_a("random");
        end

        // Three sources, only 0 and 2 requesting.
        do_reset();
        b_bad = 0;
        s_data3 = {8'h32, 8'h31, 8'h30}; s_valid3 = 3'b101; m_ready3 = 1'b1;
        for (int i = 0; i < 22; i++) cycle_a("n3_cycle");
        check("n3_count", last3_q.size() >= 4, $sformatf("%0d grants", last3_q.size()), ">=4 grants");
        for (int i = 0; i < 4 && i < last3_q.size(); i++)
            check($sformatf("n3_order[%0d]", i), last3_q[i] == ((i % 2) * 2),
                  $sformatf("src %0d", last3_q[i]), $sformatf("src %0d", (i % 2) * 2));
        check("n3_data_ready", b_bad == 0, $sformatf("%0d bad cycles", b_bad), "0 bad cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
